// File: rtl/sr_flag_pkg.sv
// Shared definitions for the SR flag arbiter: op encoding, index types and
// the round-robin pick function.
package sr_flag_pkg;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;
    localparam int   MAX_REQ  = 8;

    // Wide enough for any flag index up to M = 256.
    typedef logic [7:0] flag_idx_t;
    typedef logic [2:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t winner;
    } rr_pick_t;

    // Scans downwards so the last hit kept is the first eligible at or after ptr.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                         input req_idx_t ptr,
                                         input int n);
        rr_pick_t res;
        req_idx_t cand;
        res = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            cand = req_idx_t'((int'(ptr) + i) % n);
            if (i < n && req_vec[cand]) begin
                res.valid  = 1'b1;
                res.winner = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// Single set/reset storage cell with synchronous s/r and asynchronous
// active-low clear.
module sr_cell (
    input  logic clk,
    input  logic clear,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            q <= 1'b0;
        else if (s)
            q <= 1'b1;
        else if (r)
            q <= 1'b0;
    end

    assign qbar = ~q;

    a_no_set_and_reset: assert property (@(posedge clk) disable iff (!clear) !(s && r));

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter issuing one set/reset command per cycle into a bank of
// SR flag cells, with conflict and out-of-range reporting.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int N  = 4,
    parameter int M  = 8,
    parameter int IW = 3
) (
    input  logic            clk,
    input  logic            clear,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    op,
    input  logic [N*IW-1:0] idx,
    output logic [N-1:0]    gnt,
    output logic [M-1:0]    flags,
    output logic            conflict,
    output logic            oor_err
);

    logic [N-1:0] eligible;
    rr_pick_t     pick;
    req_idx_t     rr_ptr;
    logic         win_op;
    flag_idx_t    win_idx;
    logic         conflict_next;
    logic         oor_next;
    logic         cmd_valid;
    logic [M-1:0] s_vec;
    logic [M-1:0] r_vec;
    logic [M-1:0] qbar_vec;

    // A requester whose grant is currently showing sits out one cycle.
    assign eligible = req & ~gnt;
    assign pick     = rr_pick(MAX_REQ'(eligible), rr_ptr, N);

    always_comb begin
        win_op        = OP_RESET;
        win_idx       = '0;
        conflict_next = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req_idx_t'(k) == pick.winner) begin
                win_op  = op[k];
                win_idx = flag_idx_t'(idx[k*IW +: IW]);
            end
        end
        for (int k = 0; k < N; k++) begin
            if (pick.valid && eligible[k] && req_idx_t'(k) != pick.winner &&
                flag_idx_t'(idx[k*IW +: IW]) == win_idx && op[k] != win_op)
                conflict_next = 1'b1;
        end
    end

    assign oor_next  = pick.valid && (int'(win_idx) >= M);
    assign cmd_valid = pick.valid && !oor_next;

    // s and r come from complementary op terms, so a cell never sees both.
    always_comb begin
        s_vec = '0;
        r_vec = '0;
        for (int i = 0; i < M; i++) begin
            s_vec[i] = cmd_valid && (int'(win_idx) == i) && (win_op == OP_SET);
            r_vec[i] = cmd_valid && (int'(win_idx) == i) && (win_op == OP_RESET);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            conflict <= 1'b0;
            oor_err  <= 1'b0;
        end else begin
            gnt      <= '0;
            conflict <= conflict_next;
            oor_err  <= oor_next;
            if (pick.valid) begin
                gnt[pick.winner] <= 1'b1;
                rr_ptr           <= req_idx_t'((int'(pick.winner) + 1) % N);
            end
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_bank
        sr_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .s     (s_vec[g]),
            .r     (r_vec[g]),
            .q     (flags[g]),
            .qbar  (qbar_vec[g])
        );
    end

    a_sr_exclusive: assert property (@(posedge clk) disable iff (!clear) (s_vec & r_vec) == '0);
    a_qbar_complement: assert property (@(posedge clk) disable iff (!clear) (flags ^ qbar_vec) == '1);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: an M=8 and an M=6 instance share stimulus and are
// compared against a behavioural model of grants, flags and error pulses.
module tb_sr_flag_arbiter;

    logic        clk;
    logic        clear;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt8, gnt6;
    logic [7:0]  flags8;
    logic [5:0]  flags6;
    logic        conf8, conf6, oor8, oor6;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_gnt;
    logic [7:0] exp_flags8;
    logic [5:0] exp_flags6;
    logic       exp_conf;
    logic       exp_oor6;
    int         ptr;

    sr_flag_arbiter #(.N(4), .M(8), .IW(3)) dut8 (
        .clk(clk), .clear(clear), .req(req), .op(op), .idx(idx),
        .gnt(gnt8), .flags(flags8), .conflict(conf8), .oor_err(oor8)
    );

    sr_flag_arbiter #(.N(4), .M(6), .IW(3)) dut6 (
        .clk(clk), .clear(clear), .req(req), .op(op), .idx(idx),
        .gnt(gnt6), .flags(flags6), .conflict(conf6), .oor_err(oor6)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        exp_gnt    = '0;
        exp_flags8 = '0;
        exp_flags6 = '0;
        exp_conf   = 1'b0;
        exp_oor6   = 1'b0;
        ptr        = 0;
    endtask

    // Predicts the effect of the coming rising edge, then advances to the next falling edge.
    task automatic tick();
        logic [3:0] elig;
        int w, wi, c;
        elig     = req & ~exp_gnt;
        w        = -1;
        exp_conf = 1'b0;
        exp_oor6 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c = (ptr + i) % 4;
            if (w < 0 && elig[c]) w = c;
        end
        if (w >= 0) begin
            wi = int'(idx[w*3 +: 3]);
            for (int k = 0; k < 4; k++)
                if (k != w && elig[k] && idx[k*3 +: 3] == idx[w*3 +: 3] && op[k] != op[w])
                    exp_conf = 1'b1;
            exp_flags8[wi] = op[w];
            if (wi < 6) exp_flags6[wi] = op[w];
            else        exp_oor6 = 1'b1;
            exp_gnt = 4'(1 << w);
            ptr     = (w + 1) % 4;
        end else begin
            exp_gnt = '0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int k, input logic o, input int i);
        req          = 4'(1 << k);
        op[k]        = o;
        idx[k*3 +: 3] = 3'(i);
        tick();
        req = '0;
    endtask

    task automatic reset_pulse();
        req = '0;
        #2 clear = 1'b0;
        #1 model_reset();
        #1 clear = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear = 1'b0; req = '0; op = '0; idx = '0;
        model_reset();
        #7 clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (flags8 !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_flags cycle %0d: got %h want 00", i, flags8); end
            vectors++;
            if (gnt8 !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_gnt cycle %0d: got %b want 0000", i, gnt8); end
        end
        issue(0, 1'b1, 0);
        issue(1, 1'b1, 2);
        issue(2, 1'b1, 5);
        issue(3, 1'b1, 7);
        vectors++;
        if (flags8 !== 8'hA5 || flags8 !== exp_flags8) begin miscompares++; $display("[TB] FAIL load_a5: got %h want A5", flags8); end
        vectors++;
        if (flags6 !== exp_flags6) begin miscompares++; $display("[TB] FAIL load_a5_m6: got %h want %h", flags6, exp_flags6); end
        #2 clear = 1'b0;
        #1;
        vectors++;
        if (flags8 !== 8'h00 || flags6 !== 6'h00) begin miscompares++; $display("[TB] FAIL async_clear_flags: got %h/%h want 00/00", flags8, flags6); end
        vectors++;
        if (gnt8 !== 4'b0000) begin miscompares++; $display("[TB] FAIL async_clear_gnt: got %b want 0000", gnt8); end
        model_reset();
        #1 clear = 1'b1;
        tick();
    endtask

    task automatic test_single();
        issue(1, 1'b1, 5);
        vectors++;
        if (gnt8 !== 4'b0010) begin miscompares++; $display("[TB] FAIL single_set_gnt: got %b want 0010", gnt8); end
        vectors++;
        if (flags8 !== 8'h20 || flags6 !== 6'h20) begin miscompares++; $display("[TB] FAIL single_set_flags: got %h/%h want 20/20", flags8, flags6); end
        tick();
        issue(1, 1'b0, 5);
        vectors++;
        if (gnt8 !== 4'b0010) begin miscompares++; $display("[TB] FAIL single_reset_gnt: got %b want 0010", gnt8); end
        vectors++;
        if (flags8 !== 8'h00 || flags8 !== exp_flags8) begin miscompares++; $display("[TB] FAIL single_reset_flags: got %h want 00", flags8); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] seq [5];
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_pulse();
        req = 4'hF;
        op  = 4'hF;
        idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (gnt8 !== seq[i] || gnt8 !== exp_gnt) begin miscompares++; $display("[TB] FAIL rr_gnt step %0d: got %b want %b", i, gnt8, seq[i]); end
            if (i == 3) begin
                vectors++;
                if (flags8 !== 8'h0F) begin miscompares++; $display("[TB] FAIL rr_flags: got %h want 0F", flags8); end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_conflict();
        reset_pulse();
        req = 4'b0101;
        op  = 4'b0001;
        idx = {3'd0, 3'd3, 3'd0, 3'd3};
        tick();
        vectors++;
        if (gnt8 !== 4'b0001) begin miscompares++; $display("[TB] FAIL conflict_gnt: got %b want 0001", gnt8); end
        vectors++;
        if (flags8[3] !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_flag_set: got %b want 1", flags8[3]); end
        vectors++;
        if (conf8 !== 1'b1 || conf6 !== 1'b1) begin miscompares++; $display("[TB] FAIL conflict_pulse: got %b/%b want 1/1", conf8, conf6); end
        req = 4'b0100;
        tick();
        vectors++;
        if (gnt8 !== 4'b0100) begin miscompares++; $display("[TB] FAIL conflict_second_gnt: got %b want 0100", gnt8); end
        vectors++;
        if (flags8[3] !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_flag_clear: got %b want 0", flags8[3]); end
        vectors++;
        if (conf8 !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_one_cycle: got %b want 0", conf8); end
        req = '0;
        tick();
    endtask

    task automatic test_oor();
        reset_pulse();
        req = 4'b1000;
        op[3] = 1'b1;
        idx[9 +: 3] = 3'd7;
        tick();
        vectors++;
        if (gnt6 !== 4'b1000) begin miscompares++; $display("[TB] FAIL oor_gnt: got %b want 1000", gnt6); end
        vectors++;
        if (oor6 !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_pulse: got %b want 1", oor6); end
        vectors++;
        if (flags6 !== 6'h00) begin miscompares++; $display("[TB] FAIL oor_flags: got %h want 00", flags6); end
        vectors++;
        if (oor8 !== 1'b0 || flags8 !== 8'h80) begin miscompares++; $display("[TB] FAIL oor_full_width: got oor %b flags %h want 0 80", oor8, flags8); end
        req = '0;
        tick();
        vectors++;
        if (oor6 !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_one_cycle: got %b want 0", oor6); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat;
        pat = 3'b101;
        reset_pulse();
        req = 4'b0001;
        op[0] = 1'b1;
        idx[0 +: 3] = 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (gnt8[0] !== pat[2-i] || gnt8 !== exp_gnt) begin miscompares++; $display("[TB] FAIL b2b_gnt step %0d: got %b want %b", i, gnt8, exp_gnt); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_random();
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            op  = 4'($urandom);
            idx = 12'($urandom);
            tick();
            vectors++;
            if (gnt8 !== exp_gnt || gnt6 !== exp_gnt) begin miscompares++; $display("[TB] FAIL rand_gnt cycle %0d: got %b/%b want %b", i, gnt8, gnt6, exp_gnt); end
            vectors++;
            if (flags8 !== exp_flags8) begin miscompares++; $display("[TB] FAIL rand_flags8 cycle %0d: got %h want %h", i, flags8, exp_flags8); end
            vectors++;
            if (flags6 !== exp_flags6) begin miscompares++; $display("[TB] FAIL rand_flags6 cycle %0d: got %h want %h", i, flags6, exp_flags6); end
            vectors++;
            if (conf8 !== exp_conf || conf6 !== exp_conf) begin miscompares++; $display("[TB] FAIL rand_conflict cycle %0d: got %b/%b want %b", i, conf8, conf6, exp_conf); end
            vectors++;
            if (oor6 !== exp_oor6 || oor8 !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_oor cycle %0d: got %b/%b want %b/0", i, oor6, oor8, exp_oor6); end
        end
        req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_conflict();
        test_oor();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
